// File: rtl/snake_pkg.sv
// Shared types and default colours for the snake body engine.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } state_e;

  localparam logic [11:0] DEF_BODY_COLOR = 12'h0F0;
  localparam logic [11:0] DEF_HEAD_COLOR = 12'h0A0;
  localparam logic [11:0] DEF_DEAD_COLOR = 12'hF00;
  localparam logic [11:0] DEF_BG_COLOR   = 12'hFFF;

endpackage

// File: rtl/snake_seg_match.sv
// Combinational match of one cell against the active segments, optionally skipping the tail.
module snake_seg_match
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned XW      = 6,
  parameter int unsigned YW      = 6,
  parameter int unsigned LW      = 5
) (
  input  logic [XW-1:0] qx,
  input  logic [YW-1:0] qy,
  input  logic [XW-1:0] seg_x [MAX_LEN],
  input  logic [YW-1:0] seg_y [MAX_LEN],
  input  logic [LW-1:0] len,
  input  logic          excl_tail,
  output logic          hit
);

  logic [LW-1:0] lim;

  always_comb begin
    lim = excl_tail ? len - 1'b1 : len;
    hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < lim) && (seg_x[i] == qx) && (seg_y[i] == qy)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body store, mover and pixel colour lookup.
// Define SNAKE_WRAP_EN to wrap the head at grid edges instead of dying on the wall.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W     = 64,
  parameter int unsigned GRID_H     = 48,
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned INIT_LEN   = 4,
  parameter int unsigned START_X    = 32,
  parameter int unsigned START_Y    = 24,
  parameter logic [11:0] BODY_COLOR = DEF_BODY_COLOR,
  parameter logic [11:0] HEAD_COLOR = DEF_HEAD_COLOR,
  parameter logic [11:0] DEAD_COLOR = DEF_DEAD_COLOR,
  parameter logic [11:0] BG_COLOR   = DEF_BG_COLOR,
  localparam int unsigned XW = $clog2(GRID_W),
  localparam int unsigned YW = $clog2(GRID_H),
  localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic [1:0]    dir,
  input  logic          grow,
  input  logic          restart,
  input  logic [XW-1:0] h_index,
  input  logic [YW-1:0] v_index,
  output logic [11:0]   color,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          dead,
  output logic          move_done
);

  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];
  dir_e          cur_dir_q, next_dir_q;
  state_e        state_q;
  logic [LW-1:0] length_q;
  logic          grow_pend_q, move_done_q;
  logic [11:0]   color_q;

  logic [XW-1:0] cand_x;
  logic [YW-1:0] cand_y;
  logic          wall, grow_ok, self_hit, pix_hit, dir_reverse;
  logic [11:0]   color_d;

  function automatic logic [XW-1:0] init_x(int unsigned i);
    return (i < INIT_LEN) ? XW'(START_X - i) : XW'(START_X);
  endfunction

  assign dir_reverse = (dir == (cur_dir_q ^ 2'b10));
  // Growth only counts when there is room; a dropped request still lets the tail vacate.
  assign grow_ok = (grow_pend_q | grow) && (length_q < LW'(MAX_LEN));

  always_comb begin
    cand_x = seg_x_q[0];
    cand_y = seg_y_q[0];
    wall   = 1'b0;
    unique case (next_dir_q)
      DIR_UP: begin
        if (seg_y_q[0] == '0) begin
`ifdef SNAKE_WRAP_EN
          cand_y = YW'(GRID_H - 1);
`else
          wall = 1'b1;
`endif
        end else begin
          cand_y = seg_y_q[0] - 1'b1;
        end
      end
      DIR_RIGHT: begin
        if (seg_x_q[0] == XW'(GRID_W - 1)) begin
`ifdef SNAKE_WRAP_EN
          cand_x = '0;
`else
          wall = 1'b1;
`endif
        end else begin
          cand_x = seg_x_q[0] + 1'b1;
        end
      end
      DIR_DOWN: begin
        if (seg_y_q[0] == YW'(GRID_H - 1)) begin
`ifdef SNAKE_WRAP_EN
          cand_y = '0;
`else
          wall = 1'b1;
`endif
        end else begin
          cand_y = seg_y_q[0] + 1'b1;
        end
      end
      DIR_LEFT: begin
        if (seg_x_q[0] == '0) begin
`ifdef SNAKE_WRAP_EN
          cand_x = XW'(GRID_W - 1);
`else
          wall = 1'b1;
`endif
        end else begin
          cand_x = seg_x_q[0] - 1'b1;
        end
      end
      default: ;
    endcase
  end

  snake_seg_match #(
    .MAX_LEN(MAX_LEN),
    .XW     (XW),
    .YW     (YW),
    .LW     (LW)
  ) u_coll_match (
    .qx       (cand_x),
    .qy       (cand_y),
    .seg_x    (seg_x_q),
    .seg_y    (seg_y_q),
    .len      (length_q),
    .excl_tail(!grow_ok),
    .hit      (self_hit)
  );

  snake_seg_match #(
    .MAX_LEN(MAX_LEN),
    .XW     (XW),
    .YW     (YW),
    .LW     (LW)
  ) u_pix_match (
    .qx       (h_index),
    .qy       (v_index),
    .seg_x    (seg_x_q),
    .seg_y    (seg_y_q),
    .len      (length_q),
    .excl_tail(1'b0),
    .hit      (pix_hit)
  );

  always_comb begin
    color_d = BG_COLOR;
    if ((32'(h_index) >= GRID_W) || (32'(v_index) >= GRID_H)) begin
      color_d = BG_COLOR;
    end else if ((h_index == seg_x_q[0]) && (v_index == seg_y_q[0])) begin
      color_d = (state_q == ST_DEAD) ? DEAD_COLOR : HEAD_COLOR;
    end else if (pix_hit) begin
      color_d = BODY_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= YW'(START_Y);
      end
      cur_dir_q   <= DIR_RIGHT;
      next_dir_q  <= DIR_RIGHT;
      length_q    <= LW'(INIT_LEN);
      grow_pend_q <= 1'b0;
      state_q     <= ST_RUN;
      move_done_q <= 1'b0;
      color_q     <= BG_COLOR;
    end else if (restart) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= YW'(START_Y);
      end
      cur_dir_q   <= DIR_RIGHT;
      next_dir_q  <= DIR_RIGHT;
      length_q    <= LW'(INIT_LEN);
      grow_pend_q <= 1'b0;
      state_q     <= ST_RUN;
      move_done_q <= 1'b0;
      color_q     <= BG_COLOR;
    end else begin
      move_done_q <= 1'b0;
      color_q     <= color_d;
      unique case (state_q)
        ST_RUN: begin
          if (!dir_reverse) next_dir_q <= dir_e'(dir);
          if (grow) grow_pend_q <= 1'b1;
          if (step) begin
            if (wall || self_hit) begin
              state_q <= ST_DEAD;
            end else begin
              for (int i = MAX_LEN - 1; i > 0; i--) begin
                seg_x_q[i] <= seg_x_q[i-1];
                seg_y_q[i] <= seg_y_q[i-1];
              end
              seg_x_q[0]  <= cand_x;
              seg_y_q[0]  <= cand_y;
              cur_dir_q   <= next_dir_q;
              grow_pend_q <= 1'b0;
              if (grow_ok) length_q <= length_q + 1'b1;
              move_done_q <= 1'b1;
            end
          end
        end
        ST_DEAD: ;
        default: state_q <= ST_DEAD;
      endcase
    end
  end

  assign color     = color_q;
  assign head_x    = seg_x_q[0];
  assign head_y    = seg_y_q[0];
  assign length    = length_q;
  assign dead      = (state_q == ST_DEAD);
  assign move_done = move_done_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed self-checking bench for snake_body_engine (default 64x48 grid, 16 segments).
module tb_snake_body_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic [1:0]  dir = 2'd1;
  logic        grow = 1'b0;
  logic        restart = 1'b0;
  logic [5:0]  h_index = '0;
  logic [5:0]  v_index = '0;
  logic [11:0] color;
  logic [5:0]  head_x;
  logic [5:0]  head_y;
  logic [4:0]  length;
  logic        dead;
  logic        move_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  snake_body_engine u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (step),
    .dir      (dir),
    .grow     (grow),
    .restart  (restart),
    .h_index  (h_index),
    .v_index  (v_index),
    .color    (color),
    .head_x   (head_x),
    .head_y   (head_y),
    .length   (length),
    .dead     (dead),
    .move_done(move_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic restart_snake();
    dir     = 2'd1;
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic query(input string tag, input logic [5:0] h, input logic [5:0] v,
                       input logic [11:0] exp);
    h_index = h;
    v_index = v;
    tick();
    check(tag, 32'(color), 32'(exp));
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_head_x", 32'(head_x), 32);
    check("rst_head_y", 32'(head_y), 24);
    check("rst_length", 32'(length), 4);
    check("rst_dead", 32'(dead), 0);
    check("rst_move_done", 32'(move_done), 0);
    check("rst_color", 32'(color), 32'h0FFF);
    rst_n = 1'b1;

    // Three back-to-back steps right; first query sees pre-move head
    h_index = 6'd32;
    v_index = 6'd24;
    step    = 1'b1;
    tick();
    check("s1_move_done", 32'(move_done), 1);
    check("s1_head_x", 32'(head_x), 33);
    check("s1_premove_color", 32'(color), 32'h00A0);
    tick();
    check("s2_move_done", 32'(move_done), 1);
    check("s2_head_x", 32'(head_x), 34);
    tick();
    check("s3_move_done", 32'(move_done), 1);
    check("s3_head_x", 32'(head_x), 35);
    step = 1'b0;
    tick();
    check("s3_pulse_end", 32'(move_done), 0);
    check("s3_head_y", 32'(head_y), 24);
    check("s3_length", 32'(length), 4);
    query("q_tail_body", 6'd32, 6'd24, 12'h0F0);
    query("q_head", 6'd35, 6'd24, 12'h0A0);
    query("q_inactive", 6'd31, 6'd24, 12'hFFF);

    // Reversal rejected, then turn up
    restart_snake();
    check("rs_head_x", 32'(head_x), 32);
    check("rs_color", 32'(color), 32'h0FFF);
    dir = 2'd3;
    tick();
    do_step();
    check("rev_head_x", 32'(head_x), 33);
    check("rev_head_y", 32'(head_y), 24);
    dir = 2'd0;
    tick();
    do_step();
    check("up_head_x", 32'(head_x), 33);
    check("up_head_y", 32'(head_y), 23);

    // Growth saturating at 16
    restart_snake();
    for (int k = 1; k <= 14; k++) begin
      grow = 1'b1;
      tick();
      grow = 1'b0;
      do_step();
      check($sformatf("grow_len_%0d", k), 32'(length), (4 + k > 16) ? 16 : 4 + k);
    end
    grow = 1'b1;
    tick();
    grow = 1'b0;
    do_step();
    check("sat_length", 32'(length), 16);
    check("sat_head_x", 32'(head_x), 47);
    query("sat_old_tail", 6'd31, 6'd24, 12'hFFF);
    query("sat_new_tail", 6'd32, 6'd24, 12'h0F0);

    // Self-collision at length 5
    restart_snake();
    grow = 1'b1;
    tick();
    grow = 1'b0;
    do_step();
    check("c_length", 32'(length), 5);
    dir = 2'd0;
    tick();
    do_step();
    dir = 2'd3;
    tick();
    do_step();
    check("c_pre_head_x", 32'(head_x), 32);
    check("c_pre_head_y", 32'(head_y), 23);
    dir = 2'd2;
    tick();
    do_step();
    check("c_dead", 32'(dead), 1);
    check("c_no_move_done", 32'(move_done), 0);
    check("c_head_y", 32'(head_y), 23);
    query("c_dead_color", 6'd32, 6'd23, 12'hF00);
    do_step();
    check("c_ignored_step_x", 32'(head_x), 32);
    check("c_ignored_step_md", 32'(move_done), 0);
    restart_snake();
    check("c_restart_x", 32'(head_x), 32);
    check("c_restart_y", 32'(head_y), 24);
    check("c_restart_dead", 32'(dead), 0);

    // Right edge
    step = 1'b1;
    repeat (31) tick();
    step = 1'b0;
    check("e_head_x", 32'(head_x), 63);
    check("e_alive", 32'(dead), 0);
    do_step();
`ifdef SNAKE_WRAP_EN
    check("e_wrap_x", 32'(head_x), 0);
    check("e_wrap_md", 32'(move_done), 1);
    check("e_wrap_dead", 32'(dead), 0);
`else
    check("e_wall_x", 32'(head_x), 63);
    check("e_wall_md", 32'(move_done), 0);
    check("e_wall_dead", 32'(dead), 1);
`endif

    // Empty and off-grid queries, then asynchronous reset mid-move
    restart_snake();
    query("q_empty", 6'd63, 6'd47, 12'hFFF);
    query("q_offgrid", 6'd32, 6'd50, 12'hFFF);
    h_index = 6'd32;
    v_index = 6'd24;
    do_step();
    check("ar_pre_md", 32'(move_done), 1);
    check("ar_pre_color", 32'(color), 32'h00A0);
    step = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_color", 32'(color), 32'h0FFF);
    check("ar_move_done", 32'(move_done), 0);
    check("ar_head_x", 32'(head_x), 32);
    check("ar_length", 32'(length), 4);
    step = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Parametrised snake body engine. Holds up to MAX_LEN segment coordinates on a GRID_W x GRID_H cell grid and advances the snake one cell per `step` strobe. Handles steering with reversal rejection, growth, self-collision and edge handling, and answers per-pixel colour queries from the VGA scan logic. It is driven by the external frame-rate strobe and the 25 MHz pixel-domain indices, all on one clock.

## Interface
Parameters:
- GRID_W, 64, grid width in cells; XW = $clog2(GRID_W)
- GRID_H, 48, grid height in cells; YW = $clog2(GRID_H)
- MAX_LEN, 16, segment capacity; LW = $clog2(MAX_LEN+1)
- INIT_LEN, 4, length after reset/restart (2..MAX_LEN)
- START_X, 32, head column at reset (>= INIT_LEN-1)
- START_Y, 24, head row at reset
- BODY_COLOR, 12'h0F0; HEAD_COLOR, 12'h0A0; DEAD_COLOR, 12'hF00; BG_COLOR, 12'hFFF

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- step  in  1  one-cycle advance strobe
- dir  in  2  requested heading: 0 up, 1 right, 2 down, 3 left
- grow  in  1  one-cycle grow request
- restart  in  1  synchronous return to the reset state
- h_index  in  XW  queried cell column
- v_index  in  YW  queried cell row
- color  out  12  registered RGB for the queried cell
- head_x  out  XW  current head column
- head_y  out  YW  current head row
- length  out  LW  active segment count
- dead  out  1  high in DEAD state
- move_done  out  1  one-cycle pulse after an accepted move

## Operation
- Storage: seg_x/seg_y[0..MAX_LEN-1]. Segment 0 is the head. Segments with index >= length are inactive and never match.
- Reset/restart: seg[i] = (START_X-i, START_Y) for i < INIT_LEN, others = (START_X, START_Y). Sets cur_dir = right, length = INIT_LEN, grow_pend = 0, state RUN. Outputs: color = BG_COLOR, dead = 0, move_done = 0.
- Steering: dir is sampled every cycle into next_dir unless dir == cur_dir ^ 2'b10 (reversal), in which case it is ignored. cur_dir <= next_dir on each accepted move.
- grow sets grow_pend. It is consumed at the next accepted move: if length < MAX_LEN, length increments and the old tail is retained. At MAX_LEN the request is dropped. grow_pend is cleared either way.
- FSM RUN: on step, compute the candidate head from next_dir.
  - Collision check against seg[0..length-2], or seg[0..length-1] when growing (the tail vacates only when not growing).
  - Hit -> DEAD, no movement.
  - Otherwise shift seg[i] <= seg[i-1] and write the candidate to seg[0].
- FSM DEAD: step, dir and grow are ignored. Only restart or rst_n leaves DEAD.
- restart has priority over step in the same cycle.
- Pixel map:
  - h_index >= GRID_W or v_index >= GRID_H -> BG_COLOR.
  - Head match -> HEAD_COLOR (DEAD_COLOR in DEAD).
  - Active body match -> BODY_COLOR.
  - Else BG_COLOR.

## Timing
- Move: state, head_x/head_y, length and dead update on the edge that samples step=1. move_done is high for exactly the following cycle. A blocked (collision) step gives no move_done, and dead is high the following cycle.
- Pixel: 1-cycle latency from h_index/v_index to color. A query in the same cycle as a step sees the pre-move segments.
- Back-to-back steps on consecutive cycles are each processed.
- rst_n assertion mid-move aborts immediately. All outputs take their reset values asynchronously.

## Configuration
- SNAKE_WRAP_EN defined: the head wraps at edges. x = GRID_W-1 moving right -> 0; 0 moving left -> GRID_W-1; same for rows with GRID_H.
- SNAKE_WRAP_EN undefined: a move that would leave the grid is a wall collision. Enter DEAD, no movement, no move_done.

## Structure
- snake_pkg: direction enum (DIR_UP/RIGHT/DOWN/LEFT), FSM state enum (ST_RUN, ST_DEAD), and default colour constants.
- Sub-module snake_seg_match: combinational compare of one (x,y) against all active segments, with a length/exclude-tail input. Instantiated twice: once for the collision candidate, once for the pixel query.

## Test plan
- Reset, then 3 steps with dir=1 -> head (35,24), length 4, three move_done pulses, query (32,24) -> BODY_COLOR after 1 cycle.
- From reset, dir=3 (reversal) then step -> ignored, head (33,24). Then dir=0, step -> head (33,23).
- grow then step, repeated 14 times -> length saturates at 16. A further grow+step keeps length 16 and the tail advances.
- Drive up/left/down loop at length 5 into own body -> dead=1, no move_done, head query returns 12'hF00. step ignored, restart -> head (32,24), dead=0.
- With SNAKE_WRAP_EN: head at x=63, dir=1, step -> head_x 0. Without: same stimulus -> dead=1, head_x 63.
- Query h_index=63, v_index=47 (empty) -> BG_COLOR. Assert rst_n low mid-sequence -> color 12'hFFF, move_done 0 immediately.
